// File: rtl/branch_pkg.sv
// Shared types and sizing for the branch training queue.
// Every file that carries a prediction entry imports this package.
package branch_pkg;

  localparam int N     = 7;
  localparam int DEPTH = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] history;
    logic         pred_taken;
  } entry_t;

endpackage

// File: rtl/branch_train_queue_if.sv
// Predict / resolve / train channels between the predictor, the execution unit and the queue.
// The master side is the predictor and execution unit; the slave side is the queue.
interface branch_train_queue_if;
  import branch_pkg::*;

  logic         predict_valid;
  logic [N-1:0] predict_pc;
  logic         predict_taken;
  logic [N-1:0] predict_history;
  logic         predict_ready;

  logic         resolve_valid;
  logic         resolve_taken;
  logic         resolve_ready;

  logic         train_valid;
  logic         train_taken;
  logic         train_mispredicted;
  logic [N-1:0] train_history;
  logic [N-1:0] train_pc;

  logic [CW-1:0] count;

  modport master (
    output predict_valid, predict_pc, predict_taken, predict_history,
    output resolve_valid, resolve_taken,
    input  predict_ready, resolve_ready,
    input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
    input  count
  );

  modport slave (
    input  predict_valid, predict_pc, predict_taken, predict_history,
    input  resolve_valid, resolve_taken,
    output predict_ready, resolve_ready,
    output train_valid, train_taken, train_mispredicted, train_history, train_pc,
    output count
  );

endinterface

// File: rtl/branch_fifo.sv
// Synchronous in-order FIFO of prediction entries with a whole-queue flush.
// Full and empty come from the registered count only, so they carry no input-to-output path.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = branch_pkg::DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  entry_t                        push_data,
  input  logic                          pop,
  input  logic                          flush,
  output entry_t                        head_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CWL = count_width(DEPTH);

  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CWL-1:0] count_q;
  logic           push_ok;
  logic           pop_ok;
  entry_t         mem [DEPTH];

  assign full  = (count_q == CWL'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A flushed cycle belongs to the wrong path, so its push must not land.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  assign head_data = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; head, tail and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end

  property p_count_bounded;
    @(posedge clk) disable iff (!resetn) count_q <= CWL'(DEPTH);
  endproperty
  a_count_bounded: assert property (p_count_bounded);

  property p_ptr_consistent;
    @(posedge clk) disable iff (!resetn)
      (count_q != CWL'(DEPTH)) |-> (AW'(tail - head) == AW'(count_q));
  endproperty
  a_ptr_consistent: assert property (p_ptr_consistent);

endmodule

// File: rtl/branch_train_queue.sv
// Tracks in-flight gshare predictions in program order and emits the registered
// training/recovery pulse when each branch resolves; a mispredict empties the queue.
module branch_train_queue
  import branch_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  branch_train_queue_if.slave  bus
);

  entry_t        push_entry;
  entry_t        head_entry;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  logic          resolve_fire;
  logic          mispredict;
  logic          flush;

  logic          train_valid_q;
  logic          train_taken_q;
  logic          train_mispredicted_q;
  logic [N-1:0]  train_history_q;
  logic [N-1:0]  train_pc_q;

  assign push_entry = '{pc:         bus.predict_pc,
                        history:    bus.predict_history,
                        pred_taken: bus.predict_taken};

  // A resolve against an empty queue has no branch to retire and is dropped.
  assign resolve_fire = bus.resolve_valid && !empty;
  assign mispredict   = bus.resolve_taken ^ head_entry.pred_taken;
  assign flush        = resolve_fire && mispredict;

  branch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (bus.predict_valid),
    .push_data (push_entry),
    .pop       (resolve_fire),
    .flush     (flush),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign bus.predict_ready = !full;
  assign bus.resolve_ready = !empty;
  assign bus.count         = fifo_count;

  // Data fields only load on a resolve so they hold between pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      train_valid_q        <= 1'b0;
      train_taken_q        <= 1'b0;
      train_mispredicted_q <= 1'b0;
      train_history_q      <= '0;
      train_pc_q           <= '0;
    end else begin
      train_valid_q <= resolve_fire;
      if (resolve_fire) begin
        train_taken_q        <= bus.resolve_taken;
        train_mispredicted_q <= mispredict;
        train_history_q      <= head_entry.history;
        train_pc_q           <= head_entry.pc;
      end
    end
  end

  assign bus.train_valid        = train_valid_q;
  assign bus.train_taken        = train_taken_q;
  assign bus.train_mispredicted = train_mispredicted_q;
  assign bus.train_history      = train_history_q;
  assign bus.train_pc           = train_pc_q;

endmodule
